// File: rtl/coeff_placement.sv
// CAVLC coefficient placement: walks the decoded levels from highest to lowest
// frequency and drops each one at its zig-zag position using the run_before sequence.
module coeff_placement #(
  parameter int LEVEL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4:0]           TotalCoeff,
  input  logic [3:0]           total_zeros,
  input  logic [4:0]           maxNumCoeff,
  input  logic [16*LEVEL_W-1:0] level_in,
  input  logic                 run_valid,
  input  logic [3:0]           run_before,
  output logic                 run_ready,
  output logic [16*LEVEL_W-1:0] coeff_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLACE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [16*LEVEL_W-1:0]   level_q, level_d;
  logic [16*LEVEL_W-1:0]   coeff_q, coeff_d;
  logic [4:0]              tc_q, tc_d;
  logic [4:0]              pos_q, pos_d;
  logic [4:0]              i_q, i_d;
  logic [3:0]              zl_q, zl_d;
  logic                    sidx_q, sidx_d;
  logic                    err_q, err_d;

  logic                    last_s;
  logic                    ready_s;
  logic                    step_s;
  logic [3:0]              run_s;
  logic [5:0]              sum_s;
  logic [5:0]              widx_s;
  logic [LEVEL_W-1:0]      lvl_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      coeff_q <= '0;
      tc_q    <= 5'd0;
      pos_q   <= 5'd0;
      i_q     <= 5'd0;
      zl_q    <= 4'd0;
      sidx_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      coeff_q <= coeff_d;
      tc_q    <= tc_d;
      pos_q   <= pos_d;
      i_q     <= i_d;
      zl_q    <= zl_d;
      sidx_q  <= sidx_d;
      err_q   <= err_d;
    end
  end

  // The final level takes whatever zeros remain as its run, so it never handshakes.
  assign last_s  = (i_q == (tc_q - 5'd1));
  assign ready_s = (state_q == S_PLACE) && !last_s && (zl_q != 4'd0);
  assign step_s  = (state_q == S_PLACE) && (!ready_s || run_valid);
  assign run_s   = !ready_s ? 4'd0 : ((run_before > zl_q) ? zl_q : run_before);
  assign sum_s   = {1'b0, TotalCoeff} + {2'b00, total_zeros};
  assign widx_s  = {1'b0, pos_q} + {5'd0, sidx_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (TotalCoeff == 5'd0) ? S_DONE : S_PLACE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLACE: begin
        if (step_s && last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PLACE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    coeff_d = coeff_q;
    tc_d    = tc_q;
    pos_d   = pos_q;
    i_d     = i_q;
    zl_d    = zl_q;
    sidx_d  = sidx_q;
    err_d   = err_q;
    lvl_s   = '0;
    for (int k = 0; k < 16; k++) begin
      if (i_q[3:0] == 4'(k)) begin
        lvl_s = level_q[k*LEVEL_W +: LEVEL_W];
      end
    end
    if ((state_q == S_IDLE) && start) begin
      level_d = level_in;
      tc_d    = TotalCoeff;
      sidx_d  = (maxNumCoeff == 5'd15);
      coeff_d = '0;
      zl_d    = total_zeros;
      i_d     = 5'd0;
      if (sum_s > {1'b0, maxNumCoeff}) begin
        err_d = 1'b1;
        pos_d = maxNumCoeff - 5'd1;
      end else begin
        err_d = 1'b0;
        pos_d = sum_s[4:0] - 5'd1;
      end
    end else if (step_s) begin
      // Positions that wrapped below zero land above 15 and are dropped here.
      for (int k = 0; k < 16; k++) begin
        if (widx_s == 6'(k)) begin
          coeff_d[k*LEVEL_W +: LEVEL_W] = lvl_s;
        end
      end
      if (ready_s && (run_before > zl_q)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      zl_d  = zl_q - run_s;
      pos_d = pos_q - {1'b0, run_s} - 5'd1;
      i_d   = i_q + 5'd1;
    end else begin
      err_d = err_q;
    end
  end

  always_comb begin
    run_ready = ready_s;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    coeff_out = coeff_q;
    err       = err_q;
  end

endmodule
